// File: rtl/bcd_counter_n_pkg.sv
// Shared BCD constants and the nibble validity check used by the counter,
// its digit cells and the load path.
package bcd_counter_n_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    function automatic logic bcd_valid(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_counter_n_if.sv
// Control and status bundle of the N-digit BCD counter.
// The master side drives the controls; the counter is the slave.
interface bcd_counter_n_if #(
    parameter int DIGITS = 4
);
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  zero;
    logic                  max;
    logic                  co;
    logic                  err;

    modport master (
        output clr, load, load_val, en, up,
        input  count, zero, max, co, err
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, zero, max, co, err
    );
endinterface

// File: rtl/bcd_counter_n_digit.sv
// One BCD digit: nibble register that steps up or down on carry/borrow-in
// and flags when it sits at the terminal value for the current direction.
module bcd_counter_n_digit
    import bcd_counter_n_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_init,
    input  logic       i_step,
    input  logic       i_up,
    input  logic       i_load,
    input  logic [3:0] i_load_d,
    input  logic       i_clr,
    output logic [3:0] o_q,
    output logic       o_term
);

    logic [3:0] r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= i_init;
        end else if (i_clr) begin
            r_q <= BCD_MIN;
        end else if (i_load) begin
            r_q <= i_load_d;
        end else if (i_step) begin
            if (i_up) begin
                r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
            end else begin
                r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
            end
        end
    end

    assign o_q    = r_q;
    assign o_term = i_up ? (r_q == BCD_MAX) : (r_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with clear, validated load and wrap/saturate
// terminal handling; zero/max flags decode straight from the count register.
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int                  DIGITS   = 4,
    parameter bit                  SATURATE = 1'b0,
    parameter logic [4*DIGITS-1:0] INIT     = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_counter_n_if.slave  bus
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      w_count;
    logic [DIGITS-1:0] w_term;
    logic [DIGITS-1:0] w_nib_valid;
    logic [DIGITS-1:0] w_nib_max;
    logic [DIGITS-1:0] w_chain;
    logic              w_load_ok;
    logic              w_all_term;
    logic              w_tick;
    logic              r_co;
    logic              r_err;

    assign w_load_ok  = &w_nib_valid;
    assign w_all_term = &w_term;
    // A saturated counter at its terminal value must not ripple anywhere.
    assign w_tick     = bus.en & ~bus.clr & ~bus.load & ~(SATURATE & w_all_term);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        if (INIT[4*k +: 4] > BCD_MAX) begin : g_bad_init
            $error("bcd_counter_n: INIT digit %0d is not a BCD value", k);
        end

        if (k == 0) begin : g_first
            assign w_chain[k] = w_tick;
        end else begin : g_rest
            assign w_chain[k] = w_chain[k-1] & w_term[k-1];
        end

        assign w_nib_valid[k] = bcd_valid(bus.load_val[4*k +: 4]);
        assign w_nib_max[k]   = (w_count[4*k +: 4] == BCD_MAX);

        bcd_counter_n_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_init   (INIT[4*k +: 4]),
            .i_step   (w_chain[k]),
            .i_up     (bus.up),
            .i_load   (bus.load & w_load_ok),
            .i_load_d (bus.load_val[4*k +: 4]),
            .i_clr    (bus.clr),
            .o_q      (w_count[4*k +: 4]),
            .o_term   (w_term[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_co  <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_co  <= bus.en & ~bus.clr & ~bus.load & w_all_term;
            r_err <= bus.load & ~bus.clr & ~w_load_ok;
        end
    end

    assign bus.count = w_count;
    assign bus.zero  = (w_count == '0);
    assign bus.max   = &w_nib_max;
    assign bus.co    = r_co;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: three instances (wrap, saturate, 2-digit)
// checked against a decimal-arithmetic reference model.
module tb_bcd_counter_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_counter_n_if #(.DIGITS(4)) if0 ();
    bcd_counter_n_if #(.DIGITS(4)) if1 ();
    bcd_counter_n_if #(.DIGITS(2)) if2 ();

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0), .INIT(16'h0120)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1), .INIT(16'h0000)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    bcd_counter_n #(.DIGITS(2), .SATURATE(1'b0), .INIT(8'h00)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct {
        int          dut;
        logic [31:0] count;
        logic        co;
        logic        err;
        logic        zero;
        logic        max;
    } expect_t;

    expect_t sbQueue[$];

    int vectorCount = 0;
    int missCount   = 0;

    int          digitsOf [3] = '{4, 4, 2};
    bit          satOf    [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] initOf   [3] = '{32'h0120, 32'h0000, 32'h0000};
    logic [31:0] mCount   [3] = '{32'h0120, 32'h0000, 32'h0000};
    logic        mCo      [3] = '{1'b0, 1'b0, 1'b0};
    logic        mErr     [3] = '{1'b0, 1'b0, 1'b0};

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic int pow10(input int d);
        int m = 1;
        for (int k = 0; k < d; k++) m = m * 10;
        return m;
    endfunction

    function automatic int bcdToInt(input logic [31:0] v, input int d);
        int r = 0;
        for (int k = d - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] intToBcd(input int n, input int d);
        logic [31:0] r = '0;
        int          x = n;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcdOk(input logic [31:0] v, input int d);
        bit ok = 1'b1;
        for (int k = 0; k < d; k++) if (v[4*k +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Reference behaviour in plain decimal arithmetic, one edge per call.
    task automatic modelStep(input int i, input logic rstN, input logic clr,
                             input logic ld, input logic [31:0] lv,
                             input logic en, input logic up);
        int d   = digitsOf[i];
        int mod = pow10(d);
        int c   = bcdToInt(mCount[i], d);
        logic [31:0] lvMasked = lv & ((d == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4*d)) - 32'h1));
        mCo[i]  = 1'b0;
        mErr[i] = 1'b0;
        if (!rstN) begin
            c = bcdToInt(initOf[i], d);
        end else if (clr) begin
            c = 0;
        end else if (ld) begin
            if (bcdOk(lvMasked, d)) c = bcdToInt(lvMasked, d);
            else mErr[i] = 1'b1;
        end else if (en) begin
            if (up) begin
                if (c == mod - 1) begin
                    mCo[i] = 1'b1;
                    if (!satOf[i]) c = 0;
                end else begin
                    c = c + 1;
                end
            end else begin
                if (c == 0) begin
                    mCo[i] = 1'b1;
                    if (!satOf[i]) c = mod - 1;
                end else begin
                    c = c - 1;
                end
            end
        end
        mCount[i] = intToBcd(c, d);
    endtask

    task automatic applyStimulus(input int sel, input logic rstN, input logic clr,
                                 input logic ld, input logic [31:0] lv,
                                 input logic en, input logic up,
                                 input bit glitch, input string tag);
        expect_t     e;
        expect_t     got;
        logic [31:0] obsCount;
        logic        obsCo, obsErr, obsZero, obsMax;
        @(negedge clk);
        rst_n = rstN;
        if0.clr = 1'b0; if0.load = 1'b0; if0.load_val = '0; if0.en = 1'b0; if0.up = 1'b0;
        if1.clr = 1'b0; if1.load = 1'b0; if1.load_val = '0; if1.en = 1'b0; if1.up = 1'b0;
        if2.clr = 1'b0; if2.load = 1'b0; if2.load_val = '0; if2.en = 1'b0; if2.up = 1'b0;
        case (sel)
            0: begin if0.clr = clr; if0.load = ld; if0.load_val = lv[15:0]; if0.en = en; if0.up = up; end
            1: begin if1.clr = clr; if1.load = ld; if1.load_val = lv[15:0]; if1.en = en; if1.up = up; end
            default: begin if2.clr = clr; if2.load = ld; if2.load_val = lv[7:0]; if2.en = en; if2.up = up; end
        endcase
        for (int i = 0; i < 3; i++) begin
            if (i == sel) modelStep(i, rstN, clr, ld, lv, en, up);
            else          modelStep(i, rstN, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
        e.dut   = sel;
        e.count = mCount[sel];
        e.co    = mCo[sel];
        e.err   = mErr[sel];
        e.zero  = (bcdToInt(mCount[sel], digitsOf[sel]) == 0);
        e.max   = (bcdToInt(mCount[sel], digitsOf[sel]) == pow10(digitsOf[sel]) - 1);
        sbQueue.push_back(e);
        if (glitch) begin
            #1 rst_n = 1'b0;
            #2 rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
        got = sbQueue.pop_front();
        case (got.dut)
            0: begin obsCount = 32'(if0.count); obsCo = if0.co; obsErr = if0.err; obsZero = if0.zero; obsMax = if0.max; end
            1: begin obsCount = 32'(if1.count); obsCo = if1.co; obsErr = if1.err; obsZero = if1.zero; obsMax = if1.max; end
            default: begin obsCount = 32'(if2.count); obsCo = if2.co; obsErr = if2.err; obsZero = if2.zero; obsMax = if2.max; end
        endcase
        checkOutput({tag, ".count"}, obsCount, got.count);
        checkOutput({tag, ".co"},    32'(obsCo),   32'(got.co));
        checkOutput({tag, ".err"},   32'(obsErr),  32'(got.err));
        checkOutput({tag, ".zero"},  32'(obsZero), 32'(got.zero));
        checkOutput({tag, ".max"},   32'(obsMax),  32'(got.max));
    endtask

    initial begin
        logic [31:0] lv;
        // Reset applies to every instance; each is then checked at its INIT.
        applyStimulus(0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rst0");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rst1");
        applyStimulus(2, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rst2");

        for (int n = 0; n < 3; n++)
            applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "up_from_init");

        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h0999, 1'b0, 1'b0, 1'b0, "ld0999");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "ripple_up");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h9999, 1'b0, 1'b0, 1'b0, "ld9999");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "wrap_up");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, "co_one_cycle");
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h9999, 1'b0, 1'b0, 1'b0, "sat_ld9999");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "sat_up1");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "sat_up2");

        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h0100, 1'b0, 1'b0, 1'b0, "ld0100");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "borrow_down");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b0, "ld0000");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "wrap_down");
        applyStimulus(1, 1'b1, 1'b0, 1'b1, 32'h0000, 1'b0, 1'b0, 1'b0, "sat_ld0000");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "sat_dn1");
        applyStimulus(1, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, "sat_dn2");

        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h0567, 1'b0, 1'b0, 1'b0, "ld0567");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h12A4, 1'b0, 1'b0, 1'b0, "bad_load");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h12A4, 1'b1, 1'b1, 1'b0, "bad_load_en");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "err_one_cycle");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 32'h4321, 1'b1, 1'b1, 1'b0, "clr_wins");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h0567, 1'b0, 1'b0, 1'b0, "reld0567");
        applyStimulus(0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "rst_wins");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, "pre_glitch");
        applyStimulus(0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, "async_glitch");

        // Countdown timer use: 60 ticks reach zero, the 61st wraps with co.
        applyStimulus(2, 1'b1, 1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 1'b0, "cd_ld60");
        for (int n = 1; n <= 61; n++)
            applyStimulus(2, 1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, $sformatf("cd%0d", n));

        for (int n = 0; n < 40; n++) begin
            lv = '0;
            for (int k = 0; k < 4; k++) lv[4*k +: 4] = 4'($urandom_range(0, 10));
            applyStimulus(int'($urandom_range(0, 1)), 1'b1, ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 3) == 0), lv, ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 1) == 1), 1'b0, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
